branch_sequencer: RTL and testbench
===================================

Name: branch_sequencer

Overview:
- Multi-cycle instruction sequencer for the KGP-RISC core.
- Owns the program counter and the carry/sign flag register.
- Drives fetch through an instruction-memory handshake and steps each instruction through FETCH/DECODE/EXEC/WB.
- Resolves branches with the core's 3-bit branch encoding, then updates the PC and the link write.

Parameters:
- PC_W, 32, PC and address width.
- OFF_W, 16, width of the signed branch offset.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request.
- imem_ack  in  1  instruction valid; IR loads this cycle.
- ir_we  out  1  instruction-register load strobe.
- is_branch  in  1  decoded branch-class instruction.
- is_link  in  1  branch writes return address.
- is_halt  in  1  decoded halt.
- br_type  in  3  branch condition code.
- use_reg_target  in  1  taken target = reg_target, otherwise PC-relative.
- reg_target  in  PC_W  register-sourced target.
- imm_offset  in  OFF_W  signed byte offset.
- rf_wr_req  in  1  instruction writes the register file.
- alu_carry  in  1  ALU carry out.
- alu_sign  in  2  ALU sign status.
- flags_we  in  1  instruction updates flags.
- alu_en  out  1  ALU execute strobe.
- rf_we  out  1  register-file write pulse.
- link_we  out  1  link write pulse.
- link_value  out  PC_W  return address.
- pc  out  PC_W  current PC.
- branch_taken  out  1  taken decision, valid in WB.
- halted  out  1  core halted.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=FETCH, pc=RESET_PC, flags {carry,sign}=0.
  - All strobes 0, halted=0, branch_taken=0, link_value=0.
- FETCH:
  - imem_req=1 while in FETCH.
  - On imem_ack=1: ir_we=1 the same cycle, go to DECODE. Otherwise stay; no timeout.
- DECODE (1 cycle):
  - Capture is_branch, is_link, is_halt, br_type, use_reg_target, reg_target, imm_offset, rf_wr_req, flags_we.
  - Captured is_halt=1 -> HALT; otherwise -> EXEC.
- EXEC (1 cycle):
  - alu_en=1.
  - Evaluate condition against the flag register as it stood before this instruction.
  - At the end of EXEC: if flags_we, flags <= {alu_carry, alu_sign}. A compare and a branch in the same instruction therefore never see each other's flags.
  - -> WB.
- Condition (taken only if captured is_branch=1):
  - 110: always.
  - 001: carry=1.
  - 010: carry=0.
  - 011: sign=01.
  - 100: sign=10.
  - 101: sign!=10.
  - 000, 111: never.
- WB (1 cycle):
  - branch_taken=cond; rf_we=rf_wr_req.
  - link_we=taken&is_link, with link_value=pc+4 (held until the next link).
  - pc <= taken ? (use_reg_target ? reg_target : pc+4+sext(imm_offset)) : pc+4.
  - -> FETCH.
- Arithmetic:
  - All PC math is modulo 2^PC_W; wrap is silent.
  - sext sign-extends OFF_W to PC_W.
  - A target with bits[1:0]!=0 is loaded unmodified.
- HALT:
  - halted=1, all strobes 0, pc frozen.
  - Leaves only via reset.
- Latency:
  - 4 cycles per instruction with zero-wait fetch (ack in the first FETCH cycle).
  - Each wait cycle adds 1.
- Strobe rules:
  - ir_we, alu_en, rf_we and link_we are single-cycle.
  - At most one strobe is high in any cycle.
- imem_ack outside FETCH is ignored.
- Reset mid-instruction: pending rf_we/link_we are discarded and pc returns to RESET_PC.

Test Plan:
1. Reset with RESET_PC=0x100; ALU op with rf_wr_req=1, imem_ack in the first FETCH cycle -> rf_we pulses in cycle 4, pc=0x104, branch_taken=0.
2. flags_we=1 with alu_carry=1, then branch br_type=001, imm_offset=-8 at pc=0x104 -> taken, pc=0x100. Repeat with br_type=010 -> pc=0x108.
3. Same instruction sets sign=10 and branches with br_type=100, prior sign=00 -> not taken; the next br_type=100 branch -> taken.
4. br_type=110, is_link=1, use_reg_target=1, reg_target=0x2000 at pc=0x40 -> link_we=1, link_value=0x44, pc=0x2000.
5. pc=0xFFFFFFFC, non-branch -> pc=0x0; imem_ack held low 3 cycles -> imem_req stays high, instruction takes 7 cycles.
6. is_halt -> halted=1, no further imem_req. Assert rst during EXEC of a later run -> pc=RESET_PC, no rf_we, FETCH restarts.

Source files
------------

// File: rtl/branch_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the KGP-RISC core.
// Owns the PC, the {carry,sign} flag register and branch resolution.
module branch_sequencer #(
  parameter int PC_W = 32,
  parameter int OFF_W = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  input  logic            imem_ack,
  output logic            ir_we,
  input  logic            is_branch,
  input  logic            is_link,
  input  logic            is_halt,
  input  logic [2:0]      br_type,
  input  logic            use_reg_target,
  input  logic [PC_W-1:0] reg_target,
  input  logic [OFF_W-1:0] imm_offset,
  input  logic            rf_wr_req,
  input  logic            alu_carry,
  input  logic [1:0]      alu_sign,
  input  logic            flags_we,
  output logic            alu_en,
  output logic            rf_we,
  output logic            link_we,
  output logic [PC_W-1:0] link_value,
  output logic [PC_W-1:0] pc,
  output logic            branch_taken,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  state_t state_reg, state_next;

  logic [PC_W-1:0]  pc_reg;
  logic [PC_W-1:0]  link_value_reg;
  logic             carry_reg;
  logic [1:0]       sign_reg;
  logic             taken_reg;

  logic             is_branch_reg;
  logic             is_link_reg;
  logic [2:0]       br_type_reg;
  logic             use_reg_target_reg;
  logic [PC_W-1:0]  reg_target_reg;
  logic [OFF_W-1:0] imm_offset_reg;
  logic             rf_wr_req_reg;
  logic             flags_we_reg;

  logic             cond_met;
  logic             cond;
  logic [PC_W-1:0]  pc_plus4;
  logic [PC_W-1:0]  rel_target;
  logic [PC_W-1:0]  pc_wb_next;

  assign pc_plus4   = pc_reg + PC_STEP;
  assign rel_target = pc_plus4 + {{(PC_W-OFF_W){imm_offset_reg[OFF_W-1]}}, imm_offset_reg};
  assign pc_wb_next = taken_reg ? (use_reg_target_reg ? reg_target_reg : rel_target) : pc_plus4;

  // Condition is judged against the flags as they stood before this instruction.
  always_comb begin
    cond_met = 1'b0;
    case (br_type_reg)
      3'b110:  cond_met = 1'b1;
      3'b001:  cond_met = carry_reg;
      3'b010:  cond_met = ~carry_reg;
      3'b011:  cond_met = (sign_reg == 2'b01);
      3'b100:  cond_met = (sign_reg == 2'b10);
      3'b101:  cond_met = (sign_reg != 2'b10);
      default: cond_met = 1'b0;
    endcase
    cond = is_branch_reg & cond_met;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    imem_req     = 1'b0;
    ir_we        = 1'b0;
    alu_en       = 1'b0;
    rf_we        = 1'b0;
    link_we      = 1'b0;
    branch_taken = 1'b0;
    halted       = 1'b0;
    case (state_reg)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we      = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: state_next = is_halt ? S_HALT : S_EXEC;
      S_EXEC: begin
        alu_en     = 1'b1;
        state_next = S_WB;
      end
      S_WB: begin
        branch_taken = taken_reg;
        rf_we        = rf_wr_req_reg;
        link_we      = taken_reg & is_link_reg;
        state_next   = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg             <= RESET_PC;
      link_value_reg     <= '0;
      carry_reg          <= 1'b0;
      sign_reg           <= 2'b00;
      taken_reg          <= 1'b0;
      is_branch_reg      <= 1'b0;
      is_link_reg        <= 1'b0;
      br_type_reg        <= 3'b000;
      use_reg_target_reg <= 1'b0;
      reg_target_reg     <= '0;
      imm_offset_reg     <= '0;
      rf_wr_req_reg      <= 1'b0;
      flags_we_reg       <= 1'b0;
    end else begin
      case (state_reg)
        S_DECODE: begin
          is_branch_reg      <= is_branch;
          is_link_reg        <= is_link;
          br_type_reg        <= br_type;
          use_reg_target_reg <= use_reg_target;
          reg_target_reg     <= reg_target;
          imm_offset_reg     <= imm_offset;
          rf_wr_req_reg      <= rf_wr_req;
          flags_we_reg       <= flags_we;
        end
        S_EXEC: begin
          taken_reg <= cond;
          if (flags_we_reg) begin
            carry_reg <= alu_carry;
            sign_reg  <= alu_sign;
          end
          // Return address is ready by WB so link_value is valid alongside link_we.
          if (cond && is_link_reg) begin
            link_value_reg <= pc_plus4;
          end
        end
        S_WB: pc_reg <= pc_wb_next;
        default: ;
      endcase
    end
  end

  assign pc         = pc_reg;
  assign link_value = link_value_reg;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed, table-driven bench for branch_sequencer: instruction vectors with
// hand-computed PC/flag outcomes, plus halt and mid-instruction reset sequences.
module tb_branch_sequencer;

  localparam logic [31:0] RPC = 32'h100;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ack, ir_we;
  logic        is_branch, is_link, is_halt;
  logic [2:0]  br_type;
  logic        use_reg_target;
  logic [31:0] reg_target;
  logic [15:0] imm_offset;
  logic        rf_wr_req, alu_carry, flags_we;
  logic [1:0]  alu_sign;
  logic        alu_en, rf_we, link_we;
  logic [31:0] link_value, pc;
  logic        branch_taken, halted;

  branch_sequencer #(.PC_W(32), .OFF_W(16), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we),
    .is_branch(is_branch), .is_link(is_link), .is_halt(is_halt),
    .br_type(br_type), .use_reg_target(use_reg_target),
    .reg_target(reg_target), .imm_offset(imm_offset),
    .rf_wr_req(rf_wr_req), .alu_carry(alu_carry), .alu_sign(alu_sign),
    .flags_we(flags_we), .alu_en(alu_en), .rf_we(rf_we), .link_we(link_we),
    .link_value(link_value), .pc(pc), .branch_taken(branch_taken),
    .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          delay;
    logic        ib, il, ih;
    logic [2:0]  bt;
    logic        ur;
    logic [31:0] rt;
    logic [15:0] im;
    logic        rw, fw, ac;
    logic [1:0]  as;
    logic        et, er, el;
    logic [31:0] ep, elv;
  } vec_t;

  vec_t vecs[22];
  int tests = 0;
  int fails = 0;

  function automatic vec_t mk(int d, logic ib, logic il, logic ih, logic [2:0] bt,
                              logic ur, logic [31:0] rt, logic [15:0] im,
                              logic rw, logic fw, logic ac, logic [1:0] as,
                              logic et, logic er, logic el,
                              logic [31:0] ep, logic [31:0] elv);
    vec_t v;
    v.delay = d; v.ib = ib; v.il = il; v.ih = ih; v.bt = bt; v.ur = ur;
    v.rt = rt; v.im = im; v.rw = rw; v.fw = fw; v.ac = ac; v.as = as;
    v.et = et; v.er = er; v.el = el; v.ep = ep; v.elv = elv;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Decode inputs are only meaningful in DECODE, ALU status only in EXEC;
  // other cycles carry inverted junk so late or early sampling shows up.
  task automatic drive_dec(input vec_t v, input bit valid);
    is_branch      = valid ? v.ib : ~v.ib;
    is_link        = valid ? v.il : ~v.il;
    is_halt        = valid ? v.ih : ~v.ih;
    br_type        = valid ? v.bt : ~v.bt;
    use_reg_target = valid ? v.ur : ~v.ur;
    reg_target     = valid ? v.rt : ~v.rt;
    imm_offset     = valid ? v.im : ~v.im;
    rf_wr_req      = valid ? v.rw : ~v.rw;
    flags_we       = valid ? v.fw : ~v.fw;
  endtask

  task automatic drive_alu(input vec_t v, input bit valid);
    alu_carry = valid ? v.ac : ~v.ac;
    alu_sign  = valid ? v.as : ~v.as;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int bad;
    int d;
    bad = 0;
    d = v.delay;
    for (int i = 0; i < d + 4; i++) begin
      @(negedge clk);
      imem_ack = (i >= d);
      drive_dec(v, i == d + 1);
      drive_alu(v, i == d + 2);
      #1;
      if (imem_req !== (i <= d)) bad++;
      if (ir_we !== (i == d)) bad++;
      if (alu_en !== (i == d + 2)) bad++;
      if (rf_we !== ((i == d + 3) && v.er)) bad++;
      if (link_we !== ((i == d + 3) && v.el)) bad++;
      if (branch_taken !== ((i == d + 3) && v.et)) bad++;
      if (halted !== 1'b0) bad++;
      if (link_we === 1'b1 && link_value !== v.elv) bad++;
    end
    @(posedge clk);
    #1;
    check($sformatf("v%0d_trace", idx), 32'(bad), 32'd0);
    check($sformatf("v%0d_pc", idx), pc, v.ep);
    check($sformatf("v%0d_link_value", idx), link_value, v.elv);
    $display("[TB] vec %0d: pc=%h link_value=%h trace_errs=%0d", idx, pc, link_value, bad);
  endtask

  initial begin
    vec_t hv;
    vec_t iv;
    int bad;

    vecs[0]  = mk(0, 0,0,0, 3'b000, 0, 32'h0,        16'h0000, 1,1,1,2'b00, 0,1,0, 32'h104, 32'h0);
    vecs[1]  = mk(0, 1,0,0, 3'b001, 0, 32'h0,        16'hFFF8, 0,0,0,2'b00, 1,0,0, 32'h100, 32'h0);
    vecs[2]  = mk(0, 1,0,0, 3'b010, 0, 32'h0,        16'hFFF8, 0,0,0,2'b00, 0,0,0, 32'h104, 32'h0);
    vecs[3]  = mk(0, 1,0,0, 3'b100, 0, 32'h0,        16'h0010, 0,1,0,2'b10, 0,0,0, 32'h108, 32'h0);
    vecs[4]  = mk(0, 1,0,0, 3'b100, 0, 32'h0,        16'h0010, 0,0,0,2'b00, 1,0,0, 32'h11C, 32'h0);
    vecs[5]  = mk(0, 1,0,0, 3'b101, 0, 32'h0,        16'h0010, 0,0,0,2'b00, 0,0,0, 32'h120, 32'h0);
    vecs[6]  = mk(0, 0,0,0, 3'b000, 0, 32'h0,        16'h0000, 1,1,0,2'b01, 0,1,0, 32'h124, 32'h0);
    vecs[7]  = mk(0, 1,0,0, 3'b011, 0, 32'h0,        16'h0020, 0,0,0,2'b00, 1,0,0, 32'h148, 32'h0);
    vecs[8]  = mk(0, 1,0,0, 3'b101, 0, 32'h0,        16'hFFB8, 0,0,0,2'b00, 1,0,0, 32'h104, 32'h0);
    vecs[9]  = mk(1, 1,0,0, 3'b010, 0, 32'h0,        16'h0008, 0,0,0,2'b00, 1,0,0, 32'h110, 32'h0);
    vecs[10] = mk(0, 1,0,0, 3'b000, 1, 32'hDEAD0000, 16'h0040, 0,0,0,2'b00, 0,0,0, 32'h114, 32'h0);
    vecs[11] = mk(0, 1,1,0, 3'b111, 0, 32'h0,        16'h0040, 0,0,0,2'b00, 0,0,0, 32'h118, 32'h0);
    vecs[12] = mk(0, 0,0,0, 3'b110, 0, 32'h0,        16'h0040, 0,0,0,2'b00, 0,0,0, 32'h11C, 32'h0);
    vecs[13] = mk(0, 1,0,0, 3'b110, 1, 32'h40,       16'h0000, 0,0,0,2'b00, 1,0,0, 32'h40,  32'h0);
    vecs[14] = mk(0, 1,1,0, 3'b110, 1, 32'h2000,     16'h0000, 0,0,0,2'b00, 1,0,1, 32'h2000, 32'h44);
    vecs[15] = mk(0, 1,1,0, 3'b110, 1, 32'hFFFFFFFC, 16'h0000, 0,0,0,2'b00, 1,0,1, 32'hFFFFFFFC, 32'h2004);
    vecs[16] = mk(3, 0,0,0, 3'b000, 0, 32'h0,        16'h0000, 1,0,0,2'b00, 0,1,0, 32'h0,   32'h2004);
    vecs[17] = mk(0, 1,0,0, 3'b110, 1, 32'h203,      16'h0000, 0,0,0,2'b00, 1,0,0, 32'h203, 32'h2004);
    vecs[18] = mk(0, 1,1,0, 3'b110, 0, 32'h0,        16'hFFFD, 0,0,0,2'b00, 1,0,1, 32'h204, 32'h207);
    vecs[19] = mk(0, 0,0,0, 3'b000, 0, 32'h0,        16'h0000, 0,1,1,2'b10, 0,0,0, 32'h208, 32'h207);
    vecs[20] = mk(0, 1,0,0, 3'b010, 0, 32'h0,        16'h0010, 0,0,0,2'b00, 1,0,0, 32'h114, 32'h0);
    vecs[21] = mk(0, 1,0,0, 3'b100, 0, 32'h0,        16'h0008, 0,0,0,2'b00, 0,0,0, 32'h118, 32'h0);
    hv = mk(0, 0,0,1, 3'b000, 0, 32'h0, 16'h0000, 1,1,1,2'b01, 0,0,0, 32'h208, 32'h207);
    iv = mk(0, 1,1,0, 3'b110, 1, 32'h3000, 16'h0000, 1,1,1,2'b01, 0,0,0, RPC, 32'h0);

    rst = 1'b0;
    imem_ack = 1'b0;
    drive_dec(vecs[0], 1'b1);
    drive_alu(vecs[0], 1'b1);
    #12;
    check("rst_pc", pc, RPC);
    check("rst_strobes", {28'd0, ir_we, alu_en, rf_we, link_we}, 32'd0);
    check("rst_taken_halted", {30'd0, branch_taken, halted}, 32'd0);
    check("rst_link_value", link_value, 32'd0);
    check("rst_imem_req", {31'd0, imem_req}, 32'd1);
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 20; k++) run_vec(vecs[k], k);

    // Halt: fetch + decode, then the core must sit idle with pc frozen.
    @(negedge clk);
    imem_ack = 1'b1;
    drive_dec(hv, 1'b0);
    @(negedge clk);
    drive_dec(hv, 1'b1);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      imem_ack = 1'b1;
      drive_dec(hv, 1'b0);
      drive_alu(hv, 1'b0);
      #1;
      if (halted !== 1'b1 || imem_req !== 1'b0 || ir_we !== 1'b0 || alu_en !== 1'b0 ||
          rf_we !== 1'b0 || link_we !== 1'b0 || pc !== 32'h208) bad++;
    end
    check("halt_idle", 32'(bad), 32'd0);
    check("halt_flag", {31'd0, halted}, 32'd1);
    check("halt_pc", pc, 32'h208);
    $display("[TB] halt: halted=%b pc=%h idle_errs=%0d", halted, pc, bad);

    @(negedge clk);
    imem_ack = 1'b0;
    rst = 1'b0;
    #1;
    check("rst2_pc", pc, RPC);
    check("rst2_halted", {31'd0, halted}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Linking branch interrupted by reset in EXEC: nothing may commit.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      imem_ack = (i == 0);
      drive_dec(iv, i == 1);
      drive_alu(iv, i == 2);
      #1;
    end
    check("intr_exec_alu_en", {31'd0, alu_en}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("intr_rst_pc", pc, RPC);
    check("intr_rst_req", {31'd0, imem_req}, 32'd1);
    @(posedge clk);
    #1;
    check("intr_no_commit", {29'd0, rf_we, link_we, alu_en}, 32'd0);
    check("intr_link_value", link_value, 32'd0);
    $display("[TB] reset mid-EXEC: pc=%h imem_req=%b rf_we=%b", pc, imem_req, rf_we);
    @(negedge clk);
    rst = 1'b1;

    for (int k = 20; k < 22; k++) run_vec(vecs[k], k);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
